// File: rtl/frame_seq_ctrl.sv
// Frame sequencer: accumulates statistics over IN_LEN operand pairs and emits three result beats.
// Optional macro GAP_ABORT_EN: a mid-frame in_valid gap aborts the frame instead of pausing it.
module frame_seq_ctrl #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned IN_LEN = 16,
   parameter int unsigned OUT_W  = 2 * DATA_W + $clog2(IN_LEN)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_1,
   input  logic [DATA_W-1:0] in_2,
   output logic              out_valid,
   output logic [OUT_W-1:0]  out_1,
   output logic [OUT_W-1:0]  out_2,
   output logic              busy
);

   localparam int unsigned CNT_W  = $clog2(IN_LEN + 1);
   localparam int unsigned PROD_W = 2 * DATA_W;

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_FINAL, S_OUT0, S_OUT1, S_OUT2
   } state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [OUT_W-1:0]    sa_q, sa_d, sb_q, sb_d, dot_q, dot_d;
   logic [PROD_W-1:0]   mx_p_q, mx_p_d;
   logic [DATA_W-1:0]   mn_a_q, mn_a_d, mx_b_q, mx_b_d;
   logic                out_valid_q, out_valid_d, busy_q, busy_d;
   logic [OUT_W-1:0]    out_1_q, out_1_d, out_2_q, out_2_d;
   logic [PROD_W-1:0]   prod;
   logic                clr;

   // Single shared multiplier feeding both the dot product and the max-product tracker.
   assign prod = PROD_W'(in_1) * PROD_W'(in_2);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         sa_q        <= '0;
         sb_q        <= '0;
         dot_q       <= '0;
         mx_p_q      <= '0;
         mn_a_q      <= '1;
         mx_b_q      <= '0;
         out_valid_q <= 1'b0;
         out_1_q     <= '0;
         out_2_q     <= '0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         sa_q        <= sa_d;
         sb_q        <= sb_d;
         dot_q       <= dot_d;
         mx_p_q      <= mx_p_d;
         mn_a_q      <= mn_a_d;
         mx_b_q      <= mx_b_d;
         out_valid_q <= out_valid_d;
         out_1_q     <= out_1_d;
         out_2_q     <= out_2_d;
         busy_q      <= busy_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      sa_d        = sa_q;
      sb_d        = sb_q;
      dot_d       = dot_q;
      mx_p_d      = mx_p_q;
      mn_a_d      = mn_a_q;
      mx_b_d      = mx_b_q;
      out_valid_d = 1'b0;
      out_1_d     = '0;
      out_2_d     = '0;
      clr         = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               sa_d    = OUT_W'(in_1);
               sb_d    = OUT_W'(in_2);
               dot_d   = OUT_W'(prod);
               mx_p_d  = prod;
               mn_a_d  = in_1;
               mx_b_d  = in_2;
               cnt_d   = CNT_W'(1);
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            if (in_valid) begin
               sa_d  = sa_q + OUT_W'(in_1);
               sb_d  = sb_q + OUT_W'(in_2);
               dot_d = dot_q + OUT_W'(prod);
               if (prod > mx_p_q) mx_p_d = prod;
               if (in_1 < mn_a_q) mn_a_d = in_1;
               if (in_2 > mx_b_q) mx_b_d = in_2;
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(IN_LEN - 1)) state_d = S_FINAL;
            end
`ifdef GAP_ABORT_EN
            else begin
               state_d = S_IDLE;
               clr     = 1'b1;
            end
`else
`endif
         end
         S_FINAL: state_d = S_OUT0;
         S_OUT0:  state_d = S_OUT1;
         S_OUT1:  state_d = S_OUT2;
         S_OUT2: begin
            state_d = S_IDLE;
            clr     = 1'b1;
         end
         default: begin
            state_d = S_IDLE;
            clr     = 1'b1;
         end
      endcase

      if (clr) begin
         cnt_d  = '0;
         sa_d   = '0;
         sb_d   = '0;
         dot_d  = '0;
         mx_p_d = '0;
         mn_a_d = '1;
         mx_b_d = '0;
      end

      // Outputs are registered from the upcoming state so each beat lines up with its OUTn cycle.
      case (state_d)
         S_OUT0: begin
            out_valid_d = 1'b1;
            out_1_d     = sa_q;
            out_2_d     = sb_q;
         end
         S_OUT1: begin
            out_valid_d = 1'b1;
            out_1_d     = dot_q;
            out_2_d     = OUT_W'(mx_p_q);
         end
         S_OUT2: begin
            out_valid_d = 1'b1;
            out_1_d     = OUT_W'(mn_a_q);
            out_2_d     = OUT_W'(mx_b_q);
         end
         default: ;
      endcase

      busy_d = (state_d != S_IDLE);
   end

   assign out_valid = out_valid_q;
   assign out_1     = out_1_q;
   assign out_2     = out_2_q;
   assign busy      = busy_q;

endmodule
